// File: rtl/m_regfile_sb_if.sv
// Register-file / scoreboard bus bundle.
//   master: drives read addresses, writeback, issue and flush requests
//   slave : returns read data, per-port busy flags, issue grant and ready
interface m_regfile_sb_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [NRD*AW-1:0]    w_rr;
    logic [NRD*WIDTH-1:0] r_rdata;
    logic [NRD-1:0]       w_busy;
    logic [AW-1:0]        w_wr;
    logic                 w_we;
    logic [WIDTH-1:0]     w_wdata;
    logic                 w_iss;
    logic [AW-1:0]        w_iss_rd;
    logic                 w_iss_ok;
    logic                 w_flush;
    logic                 r_ready;

    modport master (
        output w_rr, w_wr, w_we, w_wdata, w_iss, w_iss_rd, w_flush,
        input  r_rdata, w_busy, w_iss_ok, r_ready
    );

    modport slave (
        input  w_rr, w_wr, w_we, w_wdata, w_iss, w_iss_rd, w_flush,
        output r_rdata, w_busy, w_iss_ok, r_ready
    );
endinterface

// File: rtl/m_regfile_sb.sv
// Multi-read-port register file with per-register pending-write scoreboard.
// After reset an init sweep zeroes every register (one per cycle), then the
// block runs: combinational reads with same-cycle write bypass, one write
// port, issue reservations counted per destination and released on writeback.
// Ports:
//   w_clk  clock, w_rst synchronous active-high reset
//   bus    m_regfile_sb_if slave: w_rr/r_rdata/w_busy read side,
//          w_we/w_wr/w_wdata writeback, w_iss/w_iss_rd/w_iss_ok issue,
//          w_flush clears reservations, r_ready marks end of init sweep
module m_regfile_sb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned CW    = 2
) (
    input  logic           w_clk,
    input  logic           w_rst,
    m_regfile_sb_if.slave  bus
);
    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [CW-1:0]    cnt_q  [NREG];
    logic [CW-1:0]    cnt_d  [NREG];

    logic                 run_c;
    logic                 wb_c;
    logic                 iss_ok_c;
    logic                 iss_fire_c;
    logic [NRD*WIDTH-1:0] rdata_c;
    logic [NRD-1:0]       busy_c;

    // State and sweep index register
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: sweep walks 0..NREG-1 then enters RUN; idx wraps back to 0
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_INIT: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(NREG - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign run_c      = (state_q == ST_RUN);
    assign wb_c       = bus.w_we && run_c && (bus.w_wr != '0);
    // A full counter may still take an issue when the same register retires now
    assign iss_ok_c   = run_c && !w_rst &&
                        ((bus.w_iss_rd == '0) ||
                         (cnt_q[bus.w_iss_rd] != CNT_MAX) ||
                         (wb_c && (bus.w_wr == bus.w_iss_rd)));
    assign iss_fire_c = bus.w_iss && iss_ok_c && (bus.w_iss_rd != '0);

    // Data array: sweep zeroing during init, writeback during run
    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            if (!run_c) begin
                regs_q[idx_q] <= '0;
            end else if (wb_c) begin
                regs_q[bus.w_wr] <= bus.w_wdata;
            end
        end
    end

    // Pending counters: issue and writeback to the same register cancel out
    always_comb begin : p_cnt_next
        logic inc;
        logic dec;
        inc = 1'b0;
        dec = 1'b0;
        for (int i = 0; i < int'(NREG); i++) begin
            cnt_d[i] = cnt_q[i];
            inc      = iss_fire_c && (bus.w_iss_rd == AW'(i));
            dec      = wb_c && (bus.w_wr == AW'(i));
            if (bus.w_flush) begin
                cnt_d[i] = '0;
            end else if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec && !inc && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge w_clk) begin
        for (int i = 0; i < int'(NREG); i++) begin
            if (w_rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Read ports with bypass; busy clears when the last pending write lands now
    always_comb begin : p_read
        logic [AW-1:0] ra;
        logic          hit;
        ra      = '0;
        hit     = 1'b0;
        rdata_c = '0;
        busy_c  = '0;
        for (int k = 0; k < int'(NRD); k++) begin
            ra  = bus.w_rr[k*AW +: AW];
            hit = wb_c && (bus.w_wr == ra);
            if (run_c && (ra != '0)) begin
                rdata_c[k*WIDTH +: WIDTH] = hit ? bus.w_wdata : regs_q[ra];
                busy_c[k] = !w_rst &&
                            ((cnt_q[ra] > CW'(1)) ||
                             ((cnt_q[ra] == CW'(1)) && !hit));
            end
        end
    end

    assign bus.r_rdata  = rdata_c;
    assign bus.w_busy   = busy_c;
    assign bus.w_iss_ok = iss_ok_c;
    assign bus.r_ready  = run_c;

endmodule

// File: doc/m_regfile_sb.md
M_REGFILE_SB -- requirements
Module: m_regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter CW, default 2, scoreboard counter width per register.
REQ-005 SHALL have ports, one per line:
  w_clk  in  1  clock, all state updates on posedge;
  w_rst  in  1  synchronous active-high reset;
  w_rr  in  NRD*AW  read addresses, port k at [k*AW +: AW];
  r_rdata  out  NRD*WIDTH  read data, port k at [k*WIDTH +: WIDTH];
  w_busy  out  NRD  port k register has pending write not resolved this cycle;
  w_wr  in  AW  write address;
  w_we  in  1  write enable (writeback);
  w_wdata  in  WIDTH  write data;
  w_iss  in  1  issue: reserve destination w_iss_rd;
  w_iss_rd  in  AW  destination being reserved;
  w_iss_ok  out  1  reservation accepted this cycle;
  w_flush  in  1  clear all reservations;
  r_ready  out  1  init sweep done, block usable.

Function
REQ-006 SHALL be one clock, synchronous active-high reset; no other clock or async reset.
REQ-007 Register 0 SHALL read as 0 on every port at all times; writes and issues to address 0 SHALL be ignored; w_busy for address 0 SHALL be 0.
REQ-008 Read SHALL be combinational: r_rdata[k] = (w_we && w_wr==rr[k] && rr[k]!=0) ? w_wdata : reg[rr[k]] (same-cycle write bypass).
REQ-009 Write SHALL update reg[w_wr] at posedge when w_we=1, r_ready=1, w_wr!=0.
REQ-010 Each register SHALL own a CW-bit pending counter cnt[i].
REQ-011 w_iss_ok SHALL be 1 iff r_ready=1 and (w_iss_rd==0 or cnt[w_iss_rd] < 2^CW-1 or (w_we && w_wr==w_iss_rd)).
REQ-012 At posedge: issue-only (w_iss && w_iss_ok, rd!=0) SHALL increment cnt[rd]; writeback-only SHALL decrement cnt[w_wr], saturating at 0; both to same register SHALL leave cnt unchanged; different registers SHALL update independently.
REQ-013 w_flush=1 SHALL clear all cnt to 0 at posedge and override same-cycle issue/writeback counter updates; the data write still occurs.
REQ-014 w_busy[k] SHALL be 1 iff rr[k]!=0 and (cnt[rr[k]] > 1, or cnt[rr[k]]==1 and not (w_we && w_wr==rr[k])).
REQ-015 FSM states INIT and RUN. INIT: r_rdata ports return 0, writes/issues ignored, w_iss_ok=0, sweep counter writes 0 to reg[idx] one per cycle, idx 0..NREG-1; after idx=NREG-1 SHALL go to RUN. RUN: normal operation, r_ready=1.
REQ-016 Sweep SHALL take exactly NREG cycles; r_ready SHALL rise at the posedge ending cycle NREG after reset deasserts.

Reset
REQ-017 w_rst=1 at posedge SHALL set state INIT, sweep index 0, all cnt 0, r_ready 0; w_iss_ok 0 and w_busy all 0 while reset is held.
REQ-018 Reset mid-sweep or mid-RUN SHALL restart the full sweep; all register contents SHALL be 0 once r_ready rises.

Verification
REQ-019 Defaults; release reset, count cycles -> r_ready=1 after exactly 32 cycles; all 31 non-zero registers read 0.
REQ-020 Write reg5=0x1234 with rr0=5 same cycle -> r_rdata port0=0x1234 that cycle (bypass); next cycle still 0x1234 without we.
REQ-021 Issue rd=7 three times (CW=2) -> w_iss_ok=1,1,1 then 0 on fourth; w_busy=1 on rr=7; three writebacks to 7 -> busy drops in the cycle of the third writeback.
REQ-022 cnt[9]=1, issue rd=9 and writeback rd=9 same cycle -> cnt stays 1, busy=1 next cycle; write to reg0 with 0xFFFF -> reads 0.
REQ-023 cnt[3]=2, assert w_flush with w_we to reg3=0xAA -> next cycle cnt=0, busy=0, reg3=0xAA; later writeback to 3 leaves cnt at 0.
REQ-024 Assert w_rst at sweep idx 10 and again after reg4=0x55 in RUN -> r_ready=0, full 32-cycle sweep restarts, reg4 reads 0 afterward.
